// File: rtl/scancode_pkg.sv
// scancode_pkg: scan-code constants, key-code encodings, decoder state enum and
// the byte -> {mapped, code} lookup shared by the scancode decoder files.
// Ports: none (package).
package scancode_pkg;

   // Protocol prefixes
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // Set-2 make codes for the supported keys
   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_B = 8'h32;
   localparam logic [7:0] SC_C = 8'h21;
   localparam logic [7:0] SC_D = 8'h23;
   localparam logic [7:0] SC_E = 8'h24;
   localparam logic [7:0] SC_F = 8'h2B;
   localparam logic [7:0] SC_G = 8'h34;
   localparam logic [7:0] SC_H = 8'h33;
   localparam logic [7:0] SC_I = 8'h43;
   localparam logic [7:0] SC_J = 8'h3B;
   localparam logic [7:0] SC_0 = 8'h45;
   localparam logic [7:0] SC_1 = 8'h16;
   localparam logic [7:0] SC_2 = 8'h1E;
   localparam logic [7:0] SC_3 = 8'h26;
   localparam logic [7:0] SC_4 = 8'h25;
   localparam logic [7:0] SC_5 = 8'h2E;
   localparam logic [7:0] SC_6 = 8'h36;
   localparam logic [7:0] SC_7 = 8'h3D;
   localparam logic [7:0] SC_8 = 8'h3E;
   localparam logic [7:0] SC_9 = 8'h46;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   // Compact key-event codes
   localparam logic [4:0] KEY_A = 5'd0;
   localparam logic [4:0] KEY_B = 5'd1;
   localparam logic [4:0] KEY_C = 5'd2;
   localparam logic [4:0] KEY_D = 5'd3;
   localparam logic [4:0] KEY_E = 5'd4;
   localparam logic [4:0] KEY_F = 5'd5;
   localparam logic [4:0] KEY_G = 5'd6;
   localparam logic [4:0] KEY_H = 5'd7;
   localparam logic [4:0] KEY_I = 5'd8;
   localparam logic [4:0] KEY_J = 5'd9;
   localparam logic [4:0] KEY_DIGIT_BASE = 5'd16;
   localparam logic [4:0] KEY_ENTER = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } dec_state_t;

   typedef struct packed {
      logic       mapped;
      logic [4:0] code;
   } key_map_t;

   // Lookup of a scan-code byte; anything outside the supported set is unmapped.
   function automatic key_map_t map_scancode(input logic [7:0] sc);
      key_map_t m;
      m.mapped = 1'b1;
      m.code   = '0;
      case (sc)
         SC_A:     m.code = KEY_A;
         SC_B:     m.code = KEY_B;
         SC_C:     m.code = KEY_C;
         SC_D:     m.code = KEY_D;
         SC_E:     m.code = KEY_E;
         SC_F:     m.code = KEY_F;
         SC_G:     m.code = KEY_G;
         SC_H:     m.code = KEY_H;
         SC_I:     m.code = KEY_I;
         SC_J:     m.code = KEY_J;
         SC_0:     m.code = KEY_DIGIT_BASE + 5'd0;
         SC_1:     m.code = KEY_DIGIT_BASE + 5'd1;
         SC_2:     m.code = KEY_DIGIT_BASE + 5'd2;
         SC_3:     m.code = KEY_DIGIT_BASE + 5'd3;
         SC_4:     m.code = KEY_DIGIT_BASE + 5'd4;
         SC_5:     m.code = KEY_DIGIT_BASE + 5'd5;
         SC_6:     m.code = KEY_DIGIT_BASE + 5'd6;
         SC_7:     m.code = KEY_DIGIT_BASE + 5'd7;
         SC_8:     m.code = KEY_DIGIT_BASE + 5'd8;
         SC_9:     m.code = KEY_DIGIT_BASE + 5'd9;
         SC_ENTER: m.code = KEY_ENTER;
         default:  m.mapped = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/scancode_decoder_fifo.sv
// key_event_fifo: synchronous show-ahead FIFO; head entry is visible whenever non-empty.
// Latency: a push at edge N is visible at the head in cycle N+1 when empty.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
// Ports: clk_i/rst_ni, push_i/push_dat_i, pop_i, rd_dat_o (head, 0 when empty),
//        empty_o, full_o, count_o.
module key_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_dat_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

   // Pop on empty is ignored; push on full only succeeds alongside a pop.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Zero the head when empty so stale storage never shows up on the outputs.
   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/scancode_decoder.sv
// scancode_decoder: turns PS/2 scan-code bytes into compact key events with
// F0/E0 prefix tracking, typematic-repeat suppression and a show-ahead event FIFO.
// Latency: event-completing byte at edge N -> keyValid in cycle N+1. No upstream
// backpressure; events arriving at a full FIFO are dropped and flagged in overflow.
// Ports: clock27/resetN, byteValid/byteData in; keyValid/keyReady handshake,
//        keyCode/keyBreak head event, fillLevel, sticky overflow (clearOverflow).
module scancode_decoder
   import scancode_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int EMIT_BREAK = 0
) (
   input  logic                          clock27,
   input  logic                          resetN,
   input  logic                          byteValid,
   input  logic [7:0]                    byteData,
   input  logic                          keyReady,
   input  logic                          clearOverflow,
   output logic                          keyValid,
   output logic [4:0]                    keyCode,
   output logic                          keyBreak,
   output logic [$clog2(FIFO_DEPTH):0]   fillLevel,
   output logic                          overflow
);
   localparam logic EMIT = (EMIT_BREAK != 0);

   dec_state_t state_q, state_d;
   logic       held_valid_q, held_valid_d;
   logic [4:0] held_code_q, held_code_d;
   logic       overflow_q, overflow_d;

   key_map_t   map;
   logic       make_evt, brk_evt;
   logic       accept_make, push;
   logic       fifo_empty, fifo_full;
   logic [5:0] head_dat;

   assign map = map_scancode(byteData);

   // Decoder FSM: only moves on byteValid; flags completed make/break codes.
   always_comb begin
      state_d  = state_q;
      make_evt = 1'b0;
      brk_evt  = 1'b0;
      if (byteValid) begin
         case (state_q)
            ST_IDLE: begin
               if (byteData == SC_BREAK)    state_d = ST_BREAK;
               else if (byteData == SC_EXT) state_d = ST_EXT;
               else                         make_evt = map.mapped;
            end
            ST_BREAK: begin
               // Prefix bytes are unmapped, so a doubled prefix also lands here.
               brk_evt = map.mapped;
               state_d = ST_IDLE;
            end
            ST_EXT: begin
               state_d = (byteData == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Typematic filter: a make identical to the still-held key is a repeat.
   assign accept_make = make_evt && !(held_valid_q && (held_code_q == map.code));
   assign push        = accept_make || (brk_evt && EMIT);

   always_comb begin
      held_valid_d = held_valid_q;
      held_code_d  = held_code_q;
      overflow_d   = overflow_q;
      if (accept_make) begin
         held_valid_d = 1'b1;
         held_code_d  = map.code;
      end else if (brk_evt && held_valid_q && (held_code_q == map.code)) begin
         held_valid_d = 1'b0;
      end
      if (clearOverflow) overflow_d = 1'b0;
      // Full always implies non-empty, so keyReady alone means a pop frees a slot.
      if (push && fifo_full && !keyReady) overflow_d = 1'b1;
   end

   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_IDLE;
         held_valid_q <= 1'b0;
         held_code_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         held_valid_q <= held_valid_d;
         held_code_q  <= held_code_d;
         overflow_q   <= overflow_d;
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (6)
   ) u_fifo (
      .clk_i      (clock27),
      .rst_ni     (resetN),
      .push_i     (push),
      .push_dat_i ({brk_evt, map.code}),
      .pop_i      (keyReady),
      .rd_dat_o   (head_dat),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full),
      .count_o    (fillLevel)
   );

   assign keyValid = !fifo_empty;
   assign keyBreak = head_dat[5];
   assign keyCode  = head_dat[4:0];
   assign overflow = overflow_q;

endmodule

// File: doc/scancode_decoder.md
# scancode_decoder

Downstream of the PS/2 keyboard controller. Consumes completed 8-bit scan-code bytes and tracks the F0 (break) and E0 (extended) prefixes. Maps make/break codes for A–J, 0–9 and Enter to compact key events, suppresses typematic repeats, and buffers events in a small show-ahead FIFO with a valid/ready interface toward the game/display logic.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- EMIT_BREAK, 0: 1 = also enqueue release events; 0 = make events only.

Ports:
- clock27  in  1  system clock; all logic on posedge.
- resetN  in  1  reset, asynchronous, active-low.
- byteValid  in  1  one-cycle strobe: byteData holds a new scan-code byte.
- byteData  in  8  scan-code byte from the keyboard controller.
- keyReady  in  1  consumer accepts head event this cycle.
- clearOverflow  in  1  synchronous clear of overflow flag.
- keyValid  out  1  FIFO non-empty; head event presented.
- keyCode  out  5  head event code: A..J = 0..9, digit d = 16+d, Enter = 31.
- keyBreak  out  1  head event is a release (always 0 when EMIT_BREAK=0).
- fillLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because FIFO full.

## Operation
- Decoder FSM states: IDLE, BREAK, EXT, EXT_BREAK. It advances only on cycles with byteValid=1.
- IDLE: F0→BREAK; E0→EXT; mapped make code→make event; any other byte ignored, stay IDLE.
- BREAK: mapped code→break event, →IDLE; unmapped→IDLE, no event; F0 or E0→IDLE, no event (protocol error).
- EXT: F0→EXT_BREAK; any other byte→IDLE, no event (extended keys unsupported).
- EXT_BREAK: any byte→IDLE, no event.
- Map: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B; 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46, 0 45; Enter 5A. FA/AA/EE and all others are unmapped.
- Typematic suppression: registers heldValid and heldCode.
  - A make event whose code equals heldCode while heldValid=1 is dropped.
  - Any other make event is enqueued and sets heldCode to that code, heldValid=1.
  - A break event of heldCode clears heldValid. A break of a different key leaves the held state unchanged.
  - A break event is enqueued only if EMIT_BREAK=1.
- FIFO entry is {break, code[4:0]}.
  - Push when an event is accepted.
  - Pop when keyValid && keyReady.
  - Full and no pop: push dropped, overflow←1.
  - Full with simultaneous pop: push accepted, fillLevel unchanged.
  - Empty: keyReady ignored.
- overflow set has priority over clearOverflow in the same cycle.
- Read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: keyValid=0, keyCode=0, keyBreak=0, fillLevel=0, overflow=0. FSM=IDLE, heldValid=0, pointers=0.
- Reset asserted mid-sequence (e.g. after F0) discards the pending prefix and all queued events.
- Latency: with byteValid at edge N completing an event into an empty FIFO, keyValid=1 and keyCode valid after edge N, i.e. in cycle N+1.
- Head outputs are registered FIFO storage, stable while keyValid=1 && keyReady=0. After a pop the next entry appears the following cycle.
- Back-to-back byteValid on consecutive cycles is fully supported. There is no backpressure to the upstream side; loss is reported only through overflow.

## Structure
- Package scancode_pkg holds:
  - scan-code constants (prefixes F0/E0 and the 21 mapped codes);
  - keyCode encodings (KEY_A..KEY_J, KEY_DIGIT_BASE=16, KEY_ENTER=31);
  - FSM state enum;
  - a function for the byte→{mapped, code} lookup.
- One sub-module, key_event_fifo: parameterised synchronous show-ahead FIFO with push/pop, full/empty and count.

## Test plan
- Reset, then bytes 1C, F0, 1C with EMIT_BREAK=0 → one event keyCode=0, keyBreak=0; with EMIT_BREAK=1 → second event keyCode=0, keyBreak=1.
- Typematic: 45,45,45,F0,45,45 with EMIT_BREAK=0 → exactly two events keyCode=16; heldValid cleared after F0 45.
- Prefix handling: E0 5A, E0 F0 5A, F0 E0 5A, AA → no E0/F0 events and no break event. The trailing 5A in F0 E0 5A is consumed while the FSM is in IDLE and yields one Enter make event keyCode=31; AA yields none.
- Overflow: FIFO_DEPTH=4, keyReady=0, makes 1C,32,21,23,24 → fillLevel=4, overflow=1, head keyCode=0. Then pop ×4 → codes 0,1,2,3, keyValid=0. Then clearOverflow → overflow=0.
- Full + simultaneous pop: FIFO full, keyReady=1 in the same cycle as byteValid completing make 3B → fillLevel stays 4, no overflow, 3B's event (keyCode=9) last in order.
- Async reset asserted after F0 while FIFO holds 2 entries → all outputs 0 immediately. Next byte 1C after release yields a make event keyCode=0.
